// File: rtl/node_pkg.sv
// Shared constants, parser state/error encodings and the letter encoder
// used by the node-list streamer.
package node_pkg;

  localparam int CHAR_BITS = 5;

  localparam logic [7:0] CH_A     = 8'h61;
  localparam logic [7:0] CH_Z     = 8'h7a;
  localparam logic [7:0] CH_COLON = 8'h3a;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_NL    = 8'h0a;

  typedef enum logic [2:0] {
    S_SRC  = 3'd0,
    S_GAP  = 3'd1,
    S_DST  = 3'd2,
    S_ERR  = 3'd3,
    S_DONE = 3'd4
  } parse_state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_CHAR   = 2'd1,
    ERR_LEN    = 2'd2,
    ERR_SYNTAX = 2'd3
  } err_code_e;

  // 'a' maps to 0; callers only use this on characters already known to be letters.
  function automatic logic [CHAR_BITS-1:0] enc_char(input logic [7:0] c);
    logic [7:0] off;
    off = c - CH_A;
    return off[CHAR_BITS-1:0];
  endfunction

endpackage

// File: rtl/node_tok_fifo.sv
// Token FIFO between the node-list parser and the hashing stage.
// Entry layout is {term, src, eol, name}; head is presented combinationally.
module node_tok_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  assign full      = (cnt_q == DEPTH_C);
  assign empty     = (cnt_q == '0);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign head      = mem_q[rd_q];

  // Pointer, occupancy and storage update.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push_s) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/node_list_streamer.sv
// Node-list byte-stream parser feeding a token FIFO with marker tagging.
// Optional statistics counters are built when NODE_STATS_EN is defined.
module node_list_streamer #(
  parameter int NAME_CHARS  = 3,
  parameter int CHAR_BITS   = 5,
  parameter int FIFO_DEPTH  = 8,
  parameter int NUM_MARKERS = 4,
  parameter logic [NUM_MARKERS*NAME_CHARS*CHAR_BITS-1:0] MARKER_INIT = {
    5'd18, 5'd21, 5'd17,
    5'd14, 5'd20, 5'd19,
    5'd5,  5'd5,  5'd19,
    5'd3,  5'd0,  5'd2
  },
  parameter int CNT_W = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_vld,
  input  logic [7:0]                         i_char,
  output logic                               o_stall,
  input  logic                               i_mk_wr,
  input  logic [$clog2(NUM_MARKERS)-1:0]     i_mk_idx,
  input  logic [NAME_CHARS*CHAR_BITS-1:0]    i_mk_name,
  output logic                               o_tok_vld,
  output logic [NAME_CHARS*CHAR_BITS-1:0]    o_tok_name,
  output logic                               o_tok_src,
  output logic                               o_tok_eol,
  output logic [NUM_MARKERS-1:0]             o_tok_marker,
  input  logic                               i_tok_stall,
  output logic                               o_list_complete,
  output logic                               o_error,
  output logic [1:0]                         o_err_code,
  output logic [CNT_W-1:0]                   o_line_cnt,
  output logic [CNT_W-1:0]                   o_tok_cnt
);

  import node_pkg::*;

  localparam int NW  = NAME_CHARS * CHAR_BITS;
  localparam int LCW = $clog2(NAME_CHARS + 1);
  localparam int EW  = NW + 3;

  parse_state_e   state_q, state_d;
  err_code_e      err_q, err_d, fail_code_s;
  logic [NW-1:0]  name_q, name_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;
  logic [NW-1:0]  mk_q [NUM_MARKERS];
  logic [NW-1:0]  mk_d [NUM_MARKERS];

  logic stall_s, accept_s, legal_s, name_full_s, fail_s;
  logic is_letter_s, is_colon_s, is_space_s, is_nl_s;
  logic push_s, push_src_s, push_eol_s, push_term_s, line_inc_s, pop_s;
  logic fifo_full_s, fifo_empty_s, tok_vld_s, head_term_s;
  logic [CHAR_BITS-1:0] enc_s;
  logic [EW-1:0] push_data_s, head_s;

  assign is_letter_s = (i_char >= CH_A) && (i_char <= CH_Z);
  assign is_colon_s  = (i_char == CH_COLON);
  assign is_space_s  = (i_char == CH_SPACE);
  assign is_nl_s     = (i_char == CH_NL);
  assign legal_s     = is_letter_s | is_colon_s | is_space_s | is_nl_s;
  assign name_full_s = (lcnt_q == LCW'(NAME_CHARS));
  assign enc_s       = CHAR_BITS'(enc_char(i_char));

  // Stall uses the pre-pop full flag, so a push never meets a full FIFO.
  assign stall_s  = fifo_full_s | (state_q == S_ERR) | (state_q == S_DONE);
  assign accept_s = i_vld & ~stall_s;

  // Parser next-state, push decision and first-error capture.
  always_comb begin
    state_d     = state_q;
    name_d      = name_q;
    lcnt_d      = lcnt_q;
    err_d       = err_q;
    push_s      = 1'b0;
    push_src_s  = 1'b0;
    push_eol_s  = 1'b0;
    push_term_s = 1'b0;
    line_inc_s  = 1'b0;
    fail_s      = 1'b0;
    fail_code_s = ERR_NONE;
    if (!accept_s) begin
      state_d = state_q;
    end else if (!legal_s) begin
      fail_s      = 1'b1;
      fail_code_s = ERR_CHAR;
    end else begin
      case (state_q)
        S_SRC, S_DST: begin
          if (is_letter_s) begin
            if (name_full_s) begin
              fail_s      = 1'b1;
              fail_code_s = ERR_LEN;
            end else begin
              name_d = (name_q << CHAR_BITS) | NW'(enc_s);
              lcnt_d = lcnt_q + LCW'(1);
            end
          end else if ((state_q == S_SRC) && is_nl_s && (lcnt_q == '0)) begin
            push_s      = 1'b1;
            push_term_s = 1'b1;
            state_d     = S_DONE;
          end else if ((state_q == S_SRC) ? is_colon_s : !is_colon_s) begin
            // Right delimiter for this position; only a complete name may be pushed.
            if (name_full_s) begin
              push_s     = 1'b1;
              push_src_s = (state_q == S_SRC);
              push_eol_s = (state_q == S_DST) && is_nl_s;
              line_inc_s = (state_q == S_DST) && is_nl_s;
              name_d     = '0;
              lcnt_d     = '0;
              if (state_q == S_SRC) begin
                state_d = S_GAP;
              end else if (is_nl_s) begin
                state_d = S_SRC;
              end else begin
                state_d = S_DST;
              end
            end else begin
              fail_s      = 1'b1;
              fail_code_s = ERR_LEN;
            end
          end else begin
            fail_s      = 1'b1;
            fail_code_s = ERR_SYNTAX;
          end
        end
        S_GAP: begin
          if (is_space_s) begin
            state_d = S_DST;
          end else begin
            fail_s      = 1'b1;
            fail_code_s = ERR_SYNTAX;
          end
        end
        default: state_d = state_q;
      endcase
    end
    if (fail_s) begin
      state_d = S_ERR;
      err_d   = fail_code_s;
    end else begin
      err_d = err_q;
    end
  end

  // Parser registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_SRC;
      err_q   <= ERR_NONE;
      name_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      name_q  <= name_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign push_data_s = {push_term_s, push_src_s, push_eol_s, name_q};

  node_tok_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (head_s)
  );

  // The terminator parks at the head forever and is never offered downstream.
  assign head_term_s     = head_s[EW-1];
  assign tok_vld_s       = ~fifo_empty_s & ~head_term_s;
  assign pop_s           = tok_vld_s & ~i_tok_stall;
  assign o_tok_vld       = tok_vld_s;
  assign o_tok_src       = tok_vld_s & head_s[EW-2];
  assign o_tok_eol       = tok_vld_s & head_s[EW-3];
  assign o_tok_name      = tok_vld_s ? head_s[NW-1:0] : '0;
  assign o_list_complete = ~fifo_empty_s & head_term_s;
  assign o_stall         = stall_s;
  assign o_error         = (err_q != ERR_NONE);
  assign o_err_code      = err_q;

  // Marker table write port; out-of-range indices are ignored.
  always_comb begin
    for (int k = 0; k < NUM_MARKERS; k++) begin
      mk_d[k] = mk_q[k];
    end
    if (i_mk_wr && (int'(i_mk_idx) < NUM_MARKERS)) begin
      mk_d[i_mk_idx] = i_mk_name;
    end else begin
      mk_d[0] = mk_q[0];
    end
  end

  // Marker registers; entry 0 sits in the MSBs of MARKER_INIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_MARKERS; k++) begin
        mk_q[k] <= MARKER_INIT[(NUM_MARKERS-1-k)*NW +: NW];
      end
    end else begin
      for (int k = 0; k < NUM_MARKERS; k++) begin
        mk_q[k] <= mk_d[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_MARKERS; k++) begin : g_marker
    assign o_tok_marker[k] = tok_vld_s & (head_s[NW-1:0] == mk_q[k]);
  end

`ifdef NODE_STATS_EN
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d, tok_cnt_q, tok_cnt_d;

  // Saturating line-end and pop counters.
  always_comb begin
    line_cnt_d = line_cnt_q;
    tok_cnt_d  = tok_cnt_q;
    if (line_inc_s && (line_cnt_q != '1)) begin
      line_cnt_d = line_cnt_q + CNT_W'(1);
    end else begin
      line_cnt_d = line_cnt_q;
    end
    if (pop_s && (tok_cnt_q != '1)) begin
      tok_cnt_d = tok_cnt_q + CNT_W'(1);
    end else begin
      tok_cnt_d = tok_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_cnt_q <= '0;
      tok_cnt_q  <= '0;
    end else begin
      line_cnt_q <= line_cnt_d;
      tok_cnt_q  <= tok_cnt_d;
    end
  end

  assign o_line_cnt = line_cnt_q;
  assign o_tok_cnt  = tok_cnt_q;
`else
  logic stats_unused_s;
  assign stats_unused_s = line_inc_s;
  assign o_line_cnt     = '0;
  assign o_tok_cnt      = '0;
`endif

endmodule
